wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, number of pending multi-cycle-unit result slots (power of two, >=2).
REQ-002 Parameter AGE_MAX, default 4, cycles a pending result may wait before the ALU path is stalled.
REQ-003 Reset is rstn (synchronous, active-low); the clock is clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 alu_valid  input  1  single-cycle pipe result present this cycle.
REQ-007 alu_rd  input  5  destination register of the ALU result.
REQ-008 alu_data  input  32  ALU result value.
REQ-009 alu_stall  output  1  ALU result not consumed this cycle; upstream holds alu_valid/alu_rd/alu_data.
REQ-010 mc_valid  input  1  multi-cycle unit (load/div) offers a result.
REQ-011 mc_ready  output  1  arbiter accepts the offered result this cycle.
REQ-012 mc_rd  input  5  destination register of the multi-cycle result.
REQ-013 mc_data  input  32  multi-cycle result value.
REQ-014 regwrite_wb  output  1  register file write enable.
REQ-015 rd_wb  output  5  register file write address.
REQ-016 write_data_register_wb  output  32  register file write data.
REQ-017 pend_count  output  $clog2(DEPTH)+1  number of queued multi-cycle results.

Function
REQ-018 mc_ready SHALL equal (pend_count < DEPTH), derived from registered state only; no same-cycle pop credit.
REQ-019 A transfer SHALL occur when mc_valid && mc_ready; with mc_rd != 0 the {rd,data} pair enters the FIFO at that edge; with mc_rd == 0 it SHALL be accepted and discarded.
REQ-020 Each cycle exactly one source is selected: FIFO head if age == AGE_MAX; else ALU if alu_valid && alu_rd != 0; else FIFO head if non-empty; else none.
REQ-021 alu_stall SHALL be 1 exactly when age == AGE_MAX && alu_valid && alu_rd != 0; otherwise 0.
REQ-022 ALU results with alu_rd == 0 SHALL be consumed without a write and never stalled.
REQ-023 Outputs regwrite_wb/rd_wb/write_data_register_wb SHALL be registered: selection in cycle N appears in cycle N+1; no selection gives regwrite_wb = 0 and rd_wb/data held.
REQ-024 Latency: ALU result sampled in cycle N writes in N+1; a multi-cycle result accepted in cycle N into an empty FIFO with no competing ALU write writes in N+2.
REQ-025 regwrite_wb SHALL never be 1 with rd_wb == 0.
REQ-026 age SHALL increment each cycle the FIFO is non-empty and the head is not popped, saturating at AGE_MAX; it SHALL clear on every pop and while empty.
REQ-027 FIFO order SHALL be strict first-in first-out; simultaneous push and pop in one cycle SHALL both take effect (count unchanged).
REQ-028 Pointers SHALL wrap modulo DEPTH; pend_count SHALL never exceed DEPTH nor underflow.

Reset
REQ-029 While rstn == 0 at a rising edge: FIFO emptied, pend_count = 0, age = 0, regwrite_wb = 0, rd_wb = 0, write_data_register_wb = 0.
REQ-030 Reset mid-operation SHALL discard all queued results with no write issued in the cycle after reset; mc_ready = 1 and alu_stall = 0 in the first cycle after deassertion.

Structure
REQ-031 Package wb_pkg SHALL hold XLEN = 32, REG_ADDR_W = 5, the wb_entry_t {rd, data} struct and the default AGE_MAX.
REQ-032 The pending queue SHALL be a sub-module wb_fifo (DEPTH entries of wb_entry_t, push/pop/count, synchronous reset); arbitration, age counter and output registers stay in wb_arbiter.

Verification
REQ-033 ALU alone: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 1 -> regwrite_wb=1, rd_wb=5, data=0xDEADBEEF in cycle 2 only.
REQ-034 x0 filter: alu_rd=0 and a mc transfer with mc_rd=0 -> regwrite_wb stays 0, pend_count stays 0, mc_ready stays 1.
REQ-035 Priority and order: ALU busy every cycle (rd=1..), mc results rd=7 (0x11) then rd=8 (0x22) accepted -> pend_count=2, mc_ready=0; when ALU stops, writes rd=7 then rd=8 on consecutive cycles.
REQ-036 Starvation: continuous ALU writes, one mc result queued -> after 4 waiting cycles alu_stall=1 for one cycle, mc result written next cycle, held ALU result written the cycle after, no ALU result lost.
REQ-037 Simultaneous push/pop at pend_count=1 with ALU idle -> pend_count stays 1, writes appear in acceptance order.
REQ-038 Reset with pend_count=2 -> next cycle pend_count=0, regwrite_wb=0, mc_ready=1, no queued result ever written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its pending-result queue.
package wb_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_AGE_MAX = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Strict FIFO of pending multi-cycle results; head is visible combinationally while non-empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard against overflow/underflow even if a caller misbehaves.
    always_comb begin
        push_ok_s = push && (count_r < CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_r != CNT_W'(0));
    end

    // Entry storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: the ALU has priority, multi-cycle results queue and win once aged out.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = DEFAULT_AGE_MAX
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   alu_valid,
    input  logic [REG_ADDR_W-1:0]  alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_stall,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [REG_ADDR_W-1:0]  mc_rd,
    input  logic [XLEN-1:0]        mc_data,
    output logic                   regwrite_wb,
    output logic [REG_ADDR_W-1:0]  rd_wb,
    output logic [XLEN-1:0]        write_data_register_wb,
    output logic [$clog2(DEPTH):0] pend_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    wb_entry_t        fifo_head_s;
    wb_entry_t        push_entry_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             push_s;
    logic             pop_s;
    logic             nonempty_s;
    logic             age_hit_s;
    logic             alu_wr_s;
    wb_sel_e          sel_s;
    logic [AGE_W-1:0] age_r;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (fifo_head_s),
        .count      (fifo_count_s)
    );

    // Acceptance uses registered occupancy only; x0 results are accepted and dropped.
    always_comb begin
        mc_ready          = (fifo_count_s < CNT_W'(DEPTH));
        push_s            = mc_valid && mc_ready && (mc_rd != REG_ADDR_W'(0));
        push_entry_s.rd   = mc_rd;
        push_entry_s.data = mc_data;
        nonempty_s        = (fifo_count_s != CNT_W'(0));
        age_hit_s         = nonempty_s && (age_r == AGE_W'(AGE_MAX));
        alu_wr_s          = alu_valid && (alu_rd != REG_ADDR_W'(0));
    end

    // Source selection: aged head, then ALU, then any queued head.
    always_comb begin
        sel_s     = SEL_NONE;
        alu_stall = 1'b0;
        if (age_hit_s) begin
            sel_s     = SEL_FIFO;
            alu_stall = alu_wr_s;
        end else if (alu_wr_s) begin
            sel_s = SEL_ALU;
        end else if (nonempty_s) begin
            sel_s = SEL_FIFO;
        end else begin
            sel_s = SEL_NONE;
        end
        pop_s = (sel_s == SEL_FIFO);
    end

    // Head age: counts cycles the head waits, saturating, cleared on pop or when empty.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            age_r <= AGE_W'(0);
        end else if (pop_s || !nonempty_s) begin
            age_r <= AGE_W'(0);
        end else if (age_r != AGE_W'(AGE_MAX)) begin
            age_r <= age_r + AGE_W'(1);
        end else begin
            age_r <= age_r;
        end
    end

    // Registered writeback port; address/data hold when nothing is selected.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            regwrite_wb            <= 1'b0;
            rd_wb                  <= REG_ADDR_W'(0);
            write_data_register_wb <= XLEN'(0);
        end else begin
            case (sel_s)
                SEL_ALU: begin
                    regwrite_wb            <= 1'b1;
                    rd_wb                  <= alu_rd;
                    write_data_register_wb <= alu_data;
                end
                SEL_FIFO: begin
                    regwrite_wb            <= 1'b1;
                    rd_wb                  <= fifo_head_s.rd;
                    write_data_register_wb <= fifo_head_s.data;
                end
                default: begin
                    regwrite_wb <= 1'b0;
                end
            endcase
        end
    end

    assign pend_count = fifo_count_s;

endmodule
